// File: rtl/morse_player.sv
// morse_player -- keys out a short Morse message held in a packed symbol buffer.
//
// Ports:
//   clk          system clock, rising edge
//   Top_reset    asynchronous active-high reset
//   play_start   start request, only honoured when idle
//   play_abort   stops playback at once; no done pulse
//   seq_in[39:0] symbol buffer, char i at [5i+4:5i], symbol j at bit 5i+j (1 = dash)
//   num_in[23:0] symbol count per char at [3i+2:3i], counts above 5 clamp to 5
//   char_cnt_in  number of chars to play (0..7)
//   key_out      keyed line, 1 = tone on
//   busy         playback in progress
//   done         one-cycle pulse on normal completion
//   cur_char     index of the char being timed, 0 when idle
//
// State table
//   IDLE     | waiting for play_start
//   SYM_ON   | key on for one dot or dash
//   SYM_GAP  | one-unit silence between symbols of a char
//   CHAR_GAP | three-unit silence before the next char (cur_char already advanced)
//   FINISH   | done pulse cycle, then back to IDLE

module morse_player #(
  parameter int UNIT_CYCLES = 10
) (
  input  logic        clk,
  input  logic        Top_reset,
  input  logic        play_start,
  input  logic        play_abort,
  input  logic [39:0] seq_in,
  input  logic [23:0] num_in,
  input  logic [2:0]  char_cnt_in,
  output logic        key_out,
  output logic        busy,
  output logic        done,
  output logic [2:0]  cur_char
);

  localparam int TW = $clog2(3 * UNIT_CYCLES + 1);
  // Timer holds "cycles remaining minus one", so a load of N-1 yields exactly N cycles.
  localparam logic [TW-1:0] DOT_LD  = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] DASH_LD = TW'(3 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYM_ON   = 3'd1,
    SYM_GAP  = 3'd2,
    CHAR_GAP = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [39:0]   seq_r;
  logic [23:0]   num_r;
  logic [2:0]    cnt_r;
  logic [2:0]    char_idx;
  logic [2:0]    sym_idx;

  logic [3:0]    first_pick;  // {found, index} searched over the live inputs
  logic [3:0]    next_pick;   // {found, index} searched over the snapshot after char_idx

  function automatic logic [2:0] eff_cnt(input logic [23:0] nums, input logic [2:0] idx);
    logic [2:0] n;
    n = nums[3*int'(idx) +: 3];
    return (n > 3'd5) ? 3'd5 : n;
  endfunction

  // Lowest index >= from that is below cnt and has a nonzero symbol count.
  function automatic logic [3:0] find_char(input logic [23:0] nums, input logic [2:0] cnt,
                                           input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i >= int'(from) && i < int'(cnt) && eff_cnt(nums, 3'(i)) != 3'd0)
        r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] sym_len(input logic [39:0] seq, input logic [2:0] c,
                                            input logic [2:0] s);
    return seq[5*int'(c) + int'(s)] ? DASH_LD : DOT_LD;
  endfunction

  always_comb begin
    first_pick = find_char(num_in, char_cnt_in, 4'd0);
    next_pick  = find_char(num_r, cnt_r, {1'b0, char_idx} + 4'd1);
  end

  always_ff @(posedge clk or posedge Top_reset) begin
    if (Top_reset) begin
      state    <= IDLE;
      timer    <= '0;
      seq_r    <= '0;
      num_r    <= '0;
      cnt_r    <= '0;
      char_idx <= '0;
      sym_idx  <= '0;
      key_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_char <= '0;
    end else if (play_abort && (busy || state == IDLE)) begin
      // Abort wins over a same-cycle start and silently drops any playback.
      state    <= IDLE;
      timer    <= '0;
      char_idx <= '0;
      sym_idx  <= '0;
      key_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_char <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (play_start) begin
            seq_r <= seq_in;
            num_r <= num_in;
            cnt_r <= char_cnt_in;
            if (first_pick[3]) begin
              state    <= SYM_ON;
              char_idx <= first_pick[2:0];
              cur_char <= first_pick[2:0];
              sym_idx  <= '0;
              timer    <= sym_len(seq_in, first_pick[2:0], 3'd0);
              key_out  <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end

        SYM_ON: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (({1'b0, sym_idx} + 4'd1) < {1'b0, eff_cnt(num_r, char_idx)}) begin
            state   <= SYM_GAP;
            sym_idx <= sym_idx + 3'd1;
            timer   <= DOT_LD;
            key_out <= 1'b0;
          end else if (next_pick[3]) begin
            state    <= CHAR_GAP;
            char_idx <= next_pick[2:0];
            cur_char <= next_pick[2:0];
            sym_idx  <= '0;
            timer    <= DASH_LD;
            key_out  <= 1'b0;
          end else begin
            state    <= FINISH;
            char_idx <= '0;
            cur_char <= '0;
            sym_idx  <= '0;
            timer    <= '0;
            key_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end

        SYM_GAP, CHAR_GAP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state   <= SYM_ON;
            timer   <= sym_len(seq_r, char_idx, sym_idx);
            key_out <= 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          key_out  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          cur_char <= '0;
        end
      endcase
    end
  end

endmodule
